// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 encryption controller.
// Contents: FSM state encoding, round/width constants, the forward S-box,
// the GF(2^8) doubling helper and the round-constant lookup.
package aes_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned AES_W = 128;
  localparam int unsigned RND_W = 4;

  localparam logic [RND_W-1:0] RND_FIRST = 4'd1;
  localparam logic [RND_W-1:0] RND_LAST  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } aes_fsm_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{8'd255 - b, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [RND_W-1:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_round_step.sv
// One AES-128 round, purely combinational.
// Ports:
//   state      in  128  current cipher state (byte 0 in bits 127:120, column-major)
//   key        in  128  previous round key
//   rnd        in  4    round number 1..10, selects the round constant
//   is_final   in  1    skip MixColumns (last round)
//   next_state out 128  state after SubBytes/ShiftRows/[MixColumns]/AddRoundKey
//   next_key   out 128  expanded round key for this round
module aes_round_step
  import aes_pkg::*;
(
  input  logic [AES_W-1:0] state,
  input  logic [AES_W-1:0] key,
  input  logic [RND_W-1:0] rnd,
  input  logic             is_final,
  output logic [AES_W-1:0] next_state,
  output logic [AES_W-1:0] next_key
);

  logic [31:0] w    [4];
  logic [31:0] nw   [4];
  logic [31:0] temp;
  logic [7:0]  sb   [16];
  logic [7:0]  sr   [16];
  logic [7:0]  mc   [16];
  logic [7:0]  a0, a1, a2, a3;

  always_comb begin
    w          = '{default: '0};
    nw         = '{default: '0};
    sb         = '{default: '0};
    sr         = '{default: '0};
    mc         = '{default: '0};
    a0         = '0;
    a1         = '0;
    a2         = '0;
    a3         = '0;
    next_state = '0;
    next_key   = '0;

    // Key expansion: one 4-word step of the AES-128 schedule.
    for (int unsigned i = 0; i < 4; i++) begin
      w[i] = key[127 - 32*i -: 32];
    end
    temp = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])}
           ^ {rcon(rnd), 24'h000000};
    nw[0] = w[0] ^ temp;
    nw[1] = w[1] ^ nw[0];
    nw[2] = w[2] ^ nw[1];
    nw[3] = w[3] ^ nw[2];
    next_key = {nw[0], nw[1], nw[2], nw[3]};

    // SubBytes
    for (int unsigned i = 0; i < 16; i++) begin
      sb[i] = sbox(state[127 - 8*i -: 8]);
    end

    // ShiftRows: row r rotates left by r columns.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
      end
    end

    // MixColumns
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c + 1];
      a2 = sr[4*c + 2];
      a3 = sr[4*c + 3];
      mc[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    // AddRoundKey
    for (int unsigned i = 0; i < 16; i++) begin
      next_state[127 - 8*i -: 8] = (is_final ? sr[i] : mc[i]) ^ next_key[127 - 8*i -: 8];
    end
  end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock through a
// shared combinational round step. Holds state/round-key registers and
// sequences initial AddRoundKey, rounds 1..9 and the final round 10.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   plaintext+key handshake (in_data, in_key)
//   out_valid/out_ready ciphertext handshake (out_data = state register)
//   busy                high while rounds are executing
//   round_idx           current round counter, 0 when idle
module aes128_iter_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR     = 10,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [3:0]        round_idx
);

  if (NR != aes_pkg::NR || DATA_W != AES_W) begin : g_bad_cfg
    $error("aes128_iter_ctrl supports only NR=10 and DATA_W=128");
  end

  aes_fsm_e         fsm_q, fsm_d;
  logic [AES_W-1:0] state_q, state_d;
  logic [AES_W-1:0] key_q, key_d;
  logic [RND_W-1:0] rnd_q, rnd_d;

  logic [AES_W-1:0] step_state;
  logic [AES_W-1:0] step_key;
  logic [RND_W-1:0] step_rnd;
  logic             step_final;
  logic             accept;

  // Outside ROUND/FINAL the step result is unused; pin its round input to a
  // legal value so the round-constant index never leaves 1..10.
  assign step_rnd   = busy ? rnd_q : RND_FIRST;
  assign step_final = (fsm_q == ST_FINAL);

  aes_round_step u_step (
    .state      (state_q),
    .key        (key_q),
    .rnd        (step_rnd),
    .is_final   (step_final),
    .next_state (step_state),
    .next_key   (step_key)
  );

  assign busy      = (fsm_q == ST_ROUND) || (fsm_q == ST_FINAL);
  assign out_valid = (fsm_q == ST_DONE);
  assign out_data  = state_q;
  assign round_idx = rnd_q;
  assign in_ready  = (fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;

    case (fsm_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = in_data ^ in_key;
          key_d   = in_key;
          rnd_d   = RND_FIRST;
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = step_state;
        key_d   = step_key;
        rnd_d   = rnd_q + 4'd1;
        if (rnd_q == RND_LAST - 4'd1) begin
          fsm_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        state_d = step_state;
        key_d   = step_key;
        fsm_d   = ST_DONE;
      end
      ST_DONE: begin
        // A pop may coincide with a new push; the load then matches IDLE.
        if (out_ready) begin
          if (accept) begin
            state_d = in_data ^ in_key;
            key_d   = in_key;
            rnd_d   = RND_FIRST;
            fsm_d   = ST_ROUND;
          end else begin
            rnd_d = '0;
            fsm_d = ST_IDLE;
          end
        end
      end
      default: begin
        fsm_d = ST_IDLE;
        rnd_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Scoreboard bench for aes128_iter_ctrl using FIPS-197 vectors.
module tb_aes128_iter_ctrl;

  localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round_idx;

  aes128_iter_ctrl #(.NR(10), .DATA_W(128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  int unsigned  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [127:0] exp_q[$];
  int unsigned  acc_q[$];
  logic [127:0] cur_exp = '0;
  logic         seen = 1'b0;
  int unsigned  last_pop = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Acceptance detector: an accepted block pushes its expected ciphertext
  // and the index of the accepting edge.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      acc_q.push_back(cyc + 1);
    end
  end

  // Monitor: latency on first valid cycle, data on each transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (acc_q.size() == 0) chk("unexpected_out_valid", 128'(out_valid), 128'(0));
        else chk("latency", 128'(cyc - acc_q[0]), 128'(10));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_transfer", out_data, 128'(0));
        end else begin
          chk("ciphertext", out_data, exp_q.pop_front());
          if (acc_q.size() != 0) void'(acc_q.pop_front());
        end
        last_pop = cyc + 1;
        seen = 1'b0;
      end
    end
  end

  task automatic send(input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] ct, output int unsigned acc);
    logic ok;
    ok = 1'b0;
    acc = 0;
    cur_exp  = ct;
    in_data  = pt;
    in_key   = key;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        acc = cyc + 1;
        break;
      end
    end
    chk("accept_timeout", 128'(ok), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc1, acc2;
    logic ok;

    // Reset
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_round_idx", 128'(round_idx), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;

    // Vector 1 with round trace
    send(V1_PT, V1_KEY, V1_CT, acc1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("trace_round_idx", 128'(round_idx), 128'(i));
      chk("trace_busy", 128'(busy), 128'(1));
      chk("trace_in_ready", 128'(in_ready), 128'(0));
    end
    @(negedge clk);
    chk("done_busy", 128'(busy), 128'(0));
    chk("done_out_valid", 128'(out_valid), 128'(1));
    wait_drain();
    @(posedge clk);
    #1;

    // Vector 2
    send(V2_PT, V2_KEY, V2_CT, acc1);
    wait_drain();
    @(posedge clk);
    #1;

    // Backpressure
    out_ready = 1'b0;
    send(V1_PT, V1_KEY, V1_CT, acc1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_valid_timeout", 128'(ok), 128'(1));
    @(posedge clk);
    #1;
    cur_exp  = V2_CT;
    in_data  = V2_PT;
    in_key   = V2_KEY;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_data", out_data, V1_CT);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_single_transfer", 128'(out_valid), 128'(0));
    end
    @(posedge clk);
    #1;

    // Back-to-back
    out_ready = 1'b1;
    send(V1_PT, V1_KEY, V1_CT, acc1);
    send(V2_PT, V2_KEY, V2_CT, acc2);
    chk("b2b_accept_on_pop", 128'(acc2), 128'(last_pop));
    chk("b2b_spacing", 128'(acc2 - acc1), 128'(11));
    wait_drain();
    @(posedge clk);
    #1;

    // Reset mid-operation
    send(V1_PT, V1_KEY, V1_CT, acc1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (round_idx == 4'd5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("midrst_reach_round5", 128'(ok), 128'(1));
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_round_idx", 128'(round_idx), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_in_ready", 128'(in_ready), 128'(1));
    send(V1_PT, V1_KEY, V1_CT, acc1);
    wait_drain();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
